// File: rtl/rr_direct_cache_if.sv
// Request/response and slowmem bus of rr_direct_cache.
// slave  : the cache side (takes requests and memory completions, drives grants, responses, memory commands).
// master : the requester and slowmem side.
interface rr_direct_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NPORTS = 2
) ();
  logic [NPORTS-1:0]        req_valid;
  logic [NPORTS-1:0]        req_rnotw;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS*DATA_W-1:0] req_wdata;
  logic [NPORTS-1:0]        req_ready;
  logic [NPORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     mem_strobe;
  logic                     mem_rnotw;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_mfc;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_rnotw, req_addr, req_wdata, mem_mfc, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_strobe, mem_rnotw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_rnotw, req_addr, req_wdata, mem_mfc, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_strobe, mem_rnotw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_direct_cache.sv
// rr_direct_cache: direct-mapped, write-through, no-write-allocate cache, one word per line.
// NPORTS requesters share it through a round-robin arbiter. Only one request is in flight at a time,
// and misses and writes go to a single slowmem port.
// Optional feature: define CACHE_STATS_EN to add saturating read hit and read miss counters (hit_cnt, miss_cnt).
module rr_direct_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3,
  parameter int NPORTS = 2
) (
  input  logic                clk,
  input  logic                reset,
  rr_direct_cache_if.slave    bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, ptr_next, gnt_idx, cand_p, lat_gnt;
  logic               gnt_found, accept;
  int                 cand;

  logic [ADDR_W-1:0]  p_addr  [NPORTS];
  logic [DATA_W-1:0]  p_wdata [NPORTS];
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic               acc_rnotw, acc_hit;
  logic [IDX_W-1:0]   acc_idx;
  logic [TAG_W-1:0]   acc_tag;

  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [IDX_W-1:0]   lat_idx;
  logic [TAG_W-1:0]   lat_tag;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               fill, wr_hit;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES];

  // Unpack the flat per-port address and write-data buses.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      p_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      p_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: the first requesting port at or after ptr wins, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_p    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand   = (int'(ptr) + k) % NPORTS;
      cand_p = PTR_W'(cand);
      if (!gnt_found && bus.req_valid[cand_p]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_p;
      end
    end
  end

  assign ptr_next  = (gnt_idx == PTR_W'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
  assign accept    = (state == IDLE) && gnt_found && !reset;

  assign acc_addr  = p_addr[gnt_idx];
  assign acc_wdata = p_wdata[gnt_idx];
  assign acc_rnotw = bus.req_rnotw[gnt_idx];
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign acc_tag   = acc_addr[ADDR_W-1:IDX_W];
  assign acc_hit   = valid_q[acc_idx] && (tag_q[acc_idx] == acc_tag);

  assign lat_idx   = lat_addr[IDX_W-1:0];
  assign lat_tag   = lat_addr[ADDR_W-1:IDX_W];
  // A completion counts only while a read miss is waiting; a stale mfc in any other state is ignored.
  assign fill      = (state == RD_WAIT) && bus.mem_mfc;
  assign wr_hit    = (state == WR_ISSUE) && valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and all bus outputs, decoded from the current state.
  always_comb begin
    state_nx       = state;
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_data   = '0;
    bus.mem_strobe = 1'b0;
    bus.mem_rnotw  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready[gnt_idx] = 1'b1;
          if (!acc_rnotw)   state_nx = WR_ISSUE;
          else if (acc_hit) state_nx = RESP;
          else              state_nx = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        bus.mem_strobe = 1'b1;
        bus.mem_rnotw  = 1'b1;
        bus.mem_addr   = lat_addr;
        state_nx       = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_mfc) state_nx = RESP;
      end
      WR_ISSUE: begin
        bus.mem_strobe = 1'b1;
        bus.mem_rnotw  = 1'b0;
        bus.mem_addr   = lat_addr;
        bus.mem_wdata  = lat_wdata;
        state_nx       = RESP;
      end
      RESP: begin
        bus.rsp_valid[lat_gnt] = 1'b1;
        bus.rsp_data           = rsp_data_q;
        state_nx               = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arbiter pointer and the port that owns the in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      lat_gnt <= '0;
    end else if (accept) begin
      ptr     <= ptr_next;
      lat_gnt <= gnt_idx;
    end
  end

  // Line valid bits. Reset invalidates every line, which also drops any in-flight fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     valid_q          <= '0;
    else if (fill) valid_q[lat_idx] <= 1'b1;
  end

  // Request latch, response data and tag/data arrays. These hold data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr   <= acc_addr;
      lat_wdata  <= acc_wdata;
      rsp_data_q <= acc_rnotw ? data_q[acc_idx] : acc_wdata;
    end
    if (fill) begin
      data_q[lat_idx] <= bus.mem_rdata;
      tag_q[lat_idx]  <= lat_tag;
      rsp_data_q      <= bus.mem_rdata;
    end
    if (wr_hit) data_q[lat_idx] <= lat_wdata;
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count accepted reads as hits or misses. Writes are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept && acc_rnotw) begin
      if (acc_hit) hit_cnt  <= sat_inc(hit_cnt);
      else         miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rr_direct_cache.sv
// Testbench for rr_direct_cache: table of single-port transactions, plus hand-written sequences for
// arbitration order and for reset in the middle of a read. The slowmem model completes each read
// MEMDELAY cycles after its strobe. Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_rr_direct_cache;
  localparam int MEMDELAY = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_direct_cache_if #(.ADDR_W(16), .DATA_W(16), .NPORTS(2)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  rr_direct_cache #(.ADDR_W(16), .DATA_W(16), .IDX_W(3), .NPORTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // slowmem model: writes land on the strobe, reads complete MEMDELAY cycles after the strobe cycle.
  logic [15:0] mem [256];
  bit   [255:0] written;
  int          mcnt = 0;
  logic [7:0]  maddr = 8'h00;
  logic        mfc_r = 1'b0;
  logic [15:0] mrdata_r = 16'h0000;
  assign bus.mem_mfc   = mfc_r;
  assign bus.mem_rdata = mrdata_r;

  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    if (written[a])   return mem[a];
    if (a == 8'h05)   return 16'h1234;
    if (a == 8'h0D)   return 16'h5678;
    return 16'hA000 | {8'h00, a};
  endfunction

  always @(posedge clk) begin
    mfc_r <= 1'b0;
    if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mfc_r    <= 1'b1;
        mrdata_r <= mem_rd(maddr);
      end
    end
    if (bus.mem_strobe) begin
      if (bus.mem_rnotw) begin
        mcnt  <= MEMDELAY - 1;
        maddr <= bus.mem_addr[7:0];
      end else begin
        mem[bus.mem_addr[7:0]]     <= bus.mem_wdata;
        written[bus.mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    int          port;
    logic        rnotw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_strb;
  } vec_t;

  // One transaction on one port. Reports response data, latency in cycles from accept, strobe activity and timeout.
  task automatic xact(input int port, input logic rnotw, input logic [15:0] addr, input logic [15:0] wdata,
                      output logic [15:0] rdata, output int lat, output int nstrb, output int soff,
                      output logic [15:0] saddr, output logic [15:0] swdata, output logic srnotw,
                      output logic [1:0] rspv, output bit timeout);
    bit acc;
    bit done;
    rdata = '0; lat = 0; nstrb = 0; soff = 0; saddr = '0; swdata = '0; srnotw = 1'b0; rspv = '0; timeout = 1'b0;
    @(negedge clk);
    bus.req_valid[port]          = 1'b1;
    bus.req_rnotw[port]          = rnotw;
    bus.req_addr[port*16 +: 16]  = addr;
    bus.req_wdata[port*16 +: 16] = wdata;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (bus.req_ready[port]) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      timeout = 1'b1;
      bus.req_valid[port] = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.req_valid[port] = 1'b0;
      done = 1'b0;
      for (int off = 1; off <= 40 && !done; off++) begin
        @(negedge clk);
        if (bus.mem_strobe) begin
          nstrb++;
          soff   = off;
          saddr  = bus.mem_addr;
          swdata = bus.mem_wdata;
          srnotw = bus.mem_rnotw;
        end
        if (bus.rsp_valid != 2'b00) begin
          done  = 1'b1;
          lat   = off;
          rspv  = bus.rsp_valid;
          rdata = bus.rsp_data;
        end
      end
      if (!done) timeout = 1'b1;
    end
  endtask

  // Both ports request together (port0 reads 0x0005, port1 reads 0x0013, both resident) and `first` must win.
  task automatic arb_pair(input int first, input logic [15:0] d0, input logic [15:0] d1);
    int second;
    logic [15:0] df, ds;
    second = 1 - first;
    df = (first == 0) ? d0 : d1;
    ds = (first == 0) ? d1 : d0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_rnotw = 2'b11;
    bus.req_addr  = {16'h0013, 16'h0005};
    #1 check($sformatf("arb%0d first ready", first), 32'(bus.req_ready), 32'(1 << first));
    @(posedge clk);
    #1 bus.req_valid[first] = 1'b0;
    @(negedge clk);
    check($sformatf("arb%0d first rsp_valid", first), 32'(bus.rsp_valid), 32'(1 << first));
    check($sformatf("arb%0d first rsp_data", first), 32'(bus.rsp_data), 32'(df));
    check($sformatf("arb%0d no accept in RESP", first), 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    check($sformatf("arb%0d second ready", first), 32'(bus.req_ready), 32'(1 << second));
    @(posedge clk);
    #1 bus.req_valid[second] = 1'b0;
    @(negedge clk);
    check($sformatf("arb%0d second rsp_valid", first), 32'(bus.rsp_valid), 32'(1 << second));
    check($sformatf("arb%0d second rsp_data", first), 32'(bus.rsp_data), 32'(ds));
    @(negedge clk);
    exp_hits += 2;
  endtask

  vec_t vecs [18];

  initial begin
    logic [15:0] rdata, saddr, swdata;
    logic        srnotw;
    logic [1:0]  rspv;
    int          lat, nstrb, soff;
    bit          tmo, mfc_seen, bad;

    //             port rnotw  addr      wdata     data      lat strobes
    vecs[0]  = '{0, 1'b1, 16'h0005, 16'h0000, 16'h1234, 5, 1};  // cold miss
    vecs[1]  = '{0, 1'b1, 16'h0005, 16'h0000, 16'h1234, 1, 0};  // hit
    vecs[2]  = '{1, 1'b1, 16'h0005, 16'h0000, 16'h1234, 1, 0};  // shared line, other port hits
    vecs[3]  = '{0, 1'b0, 16'h0005, 16'hBEEF, 16'hBEEF, 2, 1};  // write hit
    vecs[4]  = '{0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1, 0};  // line updated
    vecs[5]  = '{1, 1'b0, 16'h0013, 16'h00AA, 16'h00AA, 2, 1};  // write miss
    vecs[6]  = '{1, 1'b1, 16'h0013, 16'h0000, 16'h00AA, 5, 1};  // no allocate: miss
    vecs[7]  = '{1, 1'b1, 16'h0013, 16'h0000, 16'h00AA, 1, 0};
    vecs[8]  = '{0, 1'b1, 16'h000D, 16'h0000, 16'h5678, 5, 1};  // same index, evicts 0x0005
    vecs[9]  = '{0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 5, 1};  // evicted
    vecs[10] = '{0, 1'b1, 16'h000D, 16'h0000, 16'h5678, 5, 1};
    vecs[11] = '{0, 1'b1, 16'h000D, 16'h0000, 16'h5678, 1, 0};
    vecs[12] = '{1, 1'b0, 16'h0005, 16'h2222, 16'h2222, 2, 1};  // write miss, alias resident
    vecs[13] = '{0, 1'b1, 16'h000D, 16'h0000, 16'h5678, 1, 0};  // resident line untouched
    vecs[14] = '{0, 1'b1, 16'h0005, 16'h0000, 16'h2222, 5, 1};
    vecs[15] = '{1, 1'b1, 16'hFFFF, 16'h0000, 16'hA0FF, 5, 1};  // top index, all-ones tag
    vecs[16] = '{1, 1'b1, 16'hFFFF, 16'h0000, 16'hA0FF, 1, 0};
    vecs[17] = '{0, 1'b1, 16'h0007, 16'h0000, 16'hA007, 5, 1};  // tag 0 replaces all-ones tag

    bus.req_valid = '0;
    bus.req_rnotw = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'(0));
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("reset mem_strobe", 32'(bus.mem_strobe), 32'(0));
    check("reset mem_addr", 32'(bus.mem_addr), 32'(0));
    check("reset rsp_data", 32'(bus.rsp_data), 32'(0));
`ifdef CACHE_STATS_EN
    check("reset hit_cnt", hit_cnt, 32'(0));
    check("reset miss_cnt", miss_cnt, 32'(0));
`endif

    for (int i = 0; i < 18; i++) begin
      xact(vecs[i].port, vecs[i].rnotw, vecs[i].addr, vecs[i].wdata,
           rdata, lat, nstrb, soff, saddr, swdata, srnotw, rspv, tmo);
      check($sformatf("v%0d timeout", i), 32'(tmo), 32'(0));
      check($sformatf("v%0d rsp_valid", i), 32'(rspv), 32'(1 << vecs[i].port));
      check($sformatf("v%0d rsp_data", i), 32'(rdata), 32'(vecs[i].exp_data));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d strobes", i), 32'(nstrb), 32'(vecs[i].exp_strb));
      if (vecs[i].exp_strb != 0) begin
        check($sformatf("v%0d strobe cycle", i), 32'(soff), 32'(1));
        check($sformatf("v%0d mem_addr", i), 32'(saddr), 32'(vecs[i].addr));
        check($sformatf("v%0d mem_rnotw", i), 32'(srnotw), 32'(vecs[i].rnotw));
        if (!vecs[i].rnotw) check($sformatf("v%0d mem_wdata", i), 32'(swdata), 32'(vecs[i].wdata));
      end
      @(negedge clk);
      check($sformatf("v%0d rsp pulse ends", i), 32'(bus.rsp_valid), 32'(0));
      if (vecs[i].rnotw) begin
        if (vecs[i].exp_strb == 0) exp_hits++;
        else                       exp_miss++;
      end
    end

    // Pointer is 1 after port0's last grant. Port1 alone brings it back to 0, so the pair goes 0 then 1.
    xact(1, 1'b1, 16'h0013, 16'h0000, rdata, lat, nstrb, soff, saddr, swdata, srnotw, rspv, tmo);
    check("ptr prep1 rsp_data", 32'(rdata), 32'(16'h00AA));
    exp_hits++;
    arb_pair(0, 16'h2222, 16'h00AA);
    // Port0 alone leaves the pointer at 1, so the pair now goes 1 then 0.
    xact(0, 1'b1, 16'h0005, 16'h0000, rdata, lat, nstrb, soff, saddr, swdata, srnotw, rspv, tmo);
    check("ptr prep0 rsp_data", 32'(rdata), 32'(16'h2222));
    exp_hits++;
    arb_pair(1, 16'h2222, 16'h00AA);

`ifdef CACHE_STATS_EN
    check("stats hit_cnt", hit_cnt, 32'(exp_hits));
    check("stats miss_cnt", miss_cnt, 32'(exp_miss));
`endif

    // Reset while a read miss waits on slowmem.
    @(negedge clk);
    bus.req_valid[0]     = 1'b1;
    bus.req_rnotw[0]     = 1'b1;
    bus.req_addr[15:0]   = 16'h0021;
    #1 check("rst-mid accept", 32'(bus.req_ready), 32'(1));
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("rst-mid strobe", 32'(bus.mem_strobe), 32'(1));
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst-mid rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst-mid mem_strobe", 32'(bus.mem_strobe), 32'(0));
    check("rst-mid req_ready", 32'(bus.req_ready), 32'(0));
`ifdef CACHE_STATS_EN
    check("rst-mid hit_cnt", hit_cnt, 32'(0));
    check("rst-mid miss_cnt", miss_cnt, 32'(0));
`endif
    @(negedge clk);
    reset = 1'b0;
    mfc_seen = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_mfc) mfc_seen = 1'b1;
      if (bus.rsp_valid != 2'b00 || bus.mem_strobe) bad = 1'b1;
    end
    check("rst-mid stale mfc arrived", 32'(mfc_seen), 32'(1));
    check("rst-mid no rsp or strobe", 32'(bad), 32'(0));

    // 0x0013 hit before the reset, so it must miss now.
    xact(1, 1'b1, 16'h0013, 16'h0000, rdata, lat, nstrb, soff, saddr, swdata, srnotw, rspv, tmo);
    check("post-rst timeout", 32'(tmo), 32'(0));
    check("post-rst rsp_data", 32'(rdata), 32'(16'h00AA));
    check("post-rst latency", 32'(lat), 32'(5));
    check("post-rst strobes", 32'(nstrb), 32'(1));
`ifdef CACHE_STATS_EN
    check("post-rst hit_cnt", hit_cnt, 32'(0));
    check("post-rst miss_cnt", miss_cnt, 32'(1));
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time backstop: report and stop if the run overshoots.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
